// File: rtl/hand_frame_scheduler.sv
// hand_frame_scheduler
//
// Per-frame controller for the hand recognition path of the pong game.
// At each frame start it opens an accumulation window. Inside that window it
// counts pixels whose contour and convex-hull strengths both reach
// PIX_THRESHOLD within a fixed region of interest, and it tracks their
// bounding box. At the next frame start the window is evaluated, and the hand
// centre is published to the paddle logic over a valid/ready handshake.
//
// Optional build macro: HAND_SMOOTH_EN. When it is defined, a detected centre
// is averaged with the previously published centre, provided that the
// previous frame was also detected.
//
// Ports:
//   VGA_CLK        sole clock
//   RST            synchronous active-high reset
//   enable         run request; low parks the block in IDLE
//   frame_start    one-cycle pulse at the start of each frame
//   pixel_valid    pixel_x, pixel_y, contour_data and hull_data are valid
//   pixel_x/_y     current pixel column/row (11 bits)
//   contour_data   contour detector output for the current pixel
//   hull_data      convex hull output for the current pixel
//   res_valid      published result available
//   res_ready      consumer accepts the result
//   hand_detected  hand present in the last published frame
//   hand_x/_y      hand centre column/row
//   hit_count      qualifying pixel count of the last published frame
//   busy           high in every state except IDLE
//   overrun        sticky flag: a frame_start arrived while publishing

module hand_frame_scheduler #(
    parameter logic [7:0] PIX_THRESHOLD = 8'd64,
    parameter int         HIT_THRESHOLD = 100,
    parameter int         ROI_X0        = 0,
    parameter int         ROI_X1        = 639,
    parameter int         ROI_Y0        = 0,
    parameter int         ROI_Y1        = 479
) (
    input  logic        VGA_CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic [7:0]  contour_data,
    input  logic [7:0]  hull_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        hand_detected,
    output logic [10:0] hand_x,
    output logic [10:0] hand_y,
    output logic [19:0] hit_count,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        ACCUM,
        EVAL,
        PUBLISH
    } state_t;

    // The ROI limits are compared as signed 13-bit values. This keeps a zero
    // lower bound from collapsing into a constant unsigned comparison.
    localparam logic signed [12:0] ROI_X0_S = 13'(ROI_X0);
    localparam logic signed [12:0] ROI_X1_S = 13'(ROI_X1);
    localparam logic signed [12:0] ROI_Y0_S = 13'(ROI_Y0);
    localparam logic signed [12:0] ROI_Y1_S = 13'(ROI_Y1);
    localparam logic [19:0]        HIT_MIN  = 20'(HIT_THRESHOLD);
    localparam logic [19:0]        ACC_MAX  = 20'hFFFFF;

    state_t state;
    state_t next_state;

    logic [19:0] acc_count;
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [10:0] ymin;
    logic [10:0] ymax;

    logic signed [12:0] px_s;
    logic signed [12:0] py_s;
    logic               in_roi;
    logic               pixel_hit;
    logic               det;
    logic [11:0]        sum_x;
    logic [11:0]        sum_y;
    logic [10:0]        new_x;
    logic [10:0]        new_y;

    // Pixel qualification: both detector strengths must reach the threshold,
    // and the pixel must lie inside the inclusive ROI.
    always_comb begin
        px_s      = $signed({2'b00, pixel_x});
        py_s      = $signed({2'b00, pixel_y});
        in_roi    = (px_s >= ROI_X0_S) && (px_s <= ROI_X1_S) &&
                    (py_s >= ROI_Y0_S) && (py_s <= ROI_Y1_S);
        pixel_hit = pixel_valid && (contour_data >= PIX_THRESHOLD) &&
                    (hull_data >= PIX_THRESHOLD) && in_roi;
    end

    // Centre of the bounding box. The sum is formed at 12 bits so that the
    // halving never loses a carry.
    always_comb begin
        det   = (acc_count >= HIT_MIN);
        sum_x = {1'b0, xmin} + {1'b0, xmax};
        sum_y = {1'b0, ymin} + {1'b0, ymax};
        new_x = 11'(sum_x >> 1);
        new_y = 11'(sum_y >> 1);
`ifdef HAND_SMOOTH_EN
        // Blend with the last published centre, but only when that frame
        // also held a hand. Otherwise a stale position would drag the
        // paddle toward it.
        if (hand_detected) begin
            new_x = 11'(({1'b0, hand_x} + {1'b0, 11'(sum_x >> 1)}) >> 1);
            new_y = 11'(({1'b0, hand_y} + {1'b0, 11'(sum_y >> 1)}) >> 1);
        end
`endif
    end

    // State register.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Dropping enable abandons a frame that is still being
    // collected. Once evaluation has started, the publish always completes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) next_state = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!enable)          next_state = IDLE;
                else if (frame_start) next_state = ACCUM;
            end
            ACCUM: begin
                if (!enable)          next_state = IDLE;
                else if (frame_start) next_state = EVAL;
            end
            EVAL: begin
                next_state = PUBLISH;
            end
            PUBLISH: begin
                if (res_valid && res_ready) next_state = enable ? WAIT_FRAME : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Accumulators and published result registers. A pixel that arrives
    // together with the closing frame_start belongs to the next frame, so it
    // is not counted.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            acc_count     <= '0;
            xmin          <= '0;
            xmax          <= '0;
            ymin          <= '0;
            ymax          <= '0;
            res_valid     <= 1'b0;
            hand_detected <= 1'b0;
            hand_x        <= '0;
            hand_y        <= '0;
            hit_count     <= '0;
            overrun       <= 1'b0;
        end else begin
            case (state)
                WAIT_FRAME: begin
                    if (enable && frame_start) begin
                        acc_count <= '0;
                        xmin      <= '0;
                        xmax      <= '0;
                        ymin      <= '0;
                        ymax      <= '0;
                    end
                end
                ACCUM: begin
                    if (enable && !frame_start && pixel_hit) begin
                        if (acc_count == '0) begin
                            xmin <= pixel_x;
                            xmax <= pixel_x;
                            ymin <= pixel_y;
                            ymax <= pixel_y;
                        end else begin
                            if (pixel_x < xmin) xmin <= pixel_x;
                            if (pixel_x > xmax) xmax <= pixel_x;
                            if (pixel_y < ymin) ymin <= pixel_y;
                            if (pixel_y > ymax) ymax <= pixel_y;
                        end
                        if (acc_count != ACC_MAX) acc_count <= acc_count + 20'd1;
                    end
                end
                EVAL: begin
                    hit_count     <= acc_count;
                    hand_detected <= det;
                    if (det) begin
                        hand_x <= new_x;
                        hand_y <= new_y;
                    end
                    res_valid <= 1'b1;
                end
                PUBLISH: begin
                    if (frame_start)            overrun   <= 1'b1;
                    if (res_valid && res_ready) res_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hand_frame_scheduler.sv
// tb_hand_frame_scheduler
//
// Randomized, self-checking bench for hand_frame_scheduler. The stimulus is
// driven frame by frame. A transaction-level model tracks the qualifying
// pixel count and bounding box with plain integer arithmetic, and it predicts
// the published result. One compare process checks every output against that
// prediction on each falling clock edge. A few literal expectations pin the
// model to hand-computed cases.

module tb_hand_frame_scheduler;

    localparam int HIT_THRESHOLD = 100;
    localparam int PIX_THRESHOLD = 64;
    localparam int ROI_X1        = 639;
    localparam int ROI_Y1        = 479;

    logic        VGA_CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic        frame_start;
    logic        pixel_valid;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic [7:0]  contour_data;
    logic [7:0]  hull_data;
    logic        res_valid;
    logic        res_ready;
    logic        hand_detected;
    logic [10:0] hand_x;
    logic [10:0] hand_y;
    logic [19:0] hit_count;
    logic        busy;
    logic        overrun;

    hand_frame_scheduler dut (
        .VGA_CLK       (VGA_CLK),
        .RST           (RST),
        .enable        (enable),
        .frame_start   (frame_start),
        .pixel_valid   (pixel_valid),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .contour_data  (contour_data),
        .hull_data     (hull_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .hand_detected (hand_detected),
        .hand_x        (hand_x),
        .hand_y        (hand_y),
        .hit_count     (hit_count),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Expected output values, predicted by the model.
    logic        exp_valid;
    logic        exp_det;
    logic        exp_busy;
    logic        exp_overrun;
    logic [10:0] exp_x;
    logic [10:0] exp_y;
    logic [19:0] exp_hit;

    // Frame model state.
    int m_count;
    int m_xmin;
    int m_xmax;
    int m_ymin;
    int m_ymax;
    bit m_prev_det;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model, away from the active edge.
    always @(negedge VGA_CLK) begin
        if (check_en) begin
            check_output("res_valid", 32'(res_valid), 32'(exp_valid));
            check_output("hand_detected", 32'(hand_detected), 32'(exp_det));
            check_output("hand_x", 32'(hand_x), 32'(exp_x));
            check_output("hand_y", 32'(hand_y), 32'(exp_y));
            check_output("hit_count", 32'(hit_count), 32'(exp_hit));
            check_output("busy", 32'(busy), 32'(exp_busy));
            check_output("overrun", 32'(overrun), 32'(exp_overrun));
        end
    end

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    function automatic bit qualifies(input bit v, input int x, input int y, input int c, input int h);
        return v && (c >= PIX_THRESHOLD) && (h >= PIX_THRESHOLD) &&
               (x >= 0) && (x <= ROI_X1) && (y >= 0) && (y <= ROI_Y1);
    endfunction

    task automatic apply_stimulus(input bit v, input int x, input int y, input int c,
                                  input int h, input bit fs);
        pixel_valid  = v;
        pixel_x      = 11'(x);
        pixel_y      = 11'(y);
        contour_data = 8'(c);
        hull_data    = 8'(h);
        frame_start  = fs;
    endtask

    task automatic model_hit(input int x, input int y);
        if (m_count == 0) begin
            m_xmin = x; m_xmax = x; m_ymin = y; m_ymax = y;
        end else begin
            if (x < m_xmin) m_xmin = x;
            if (x > m_xmax) m_xmax = x;
            if (y < m_ymin) m_ymin = y;
            if (y > m_ymax) m_ymax = y;
        end
        m_count++;
    endtask

    // Predict the result that appears when the block enters PUBLISH.
    task automatic model_publish();
        int cx;
        int cy;
        exp_hit = 20'(m_count);
        exp_det = (m_count >= HIT_THRESHOLD);
        if (exp_det) begin
            cx = (m_xmin + m_xmax) / 2;
            cy = (m_ymin + m_ymax) / 2;
`ifdef HAND_SMOOTH_EN
            if (m_prev_det) begin
                cx = (int'(exp_x) + cx) / 2;
                cy = (int'(exp_y) + cy) / 2;
            end
`endif
            exp_x = 11'(cx);
            exp_y = 11'(cy);
        end
        m_prev_det = exp_det;
        exp_valid  = 1'b1;
    endtask

    task automatic model_reset();
        exp_valid = 0; exp_det = 0; exp_busy = 0; exp_overrun = 0;
        exp_x = 0; exp_y = 0; exp_hit = 0;
        m_count = 0; m_prev_det = 0;
    endtask

    // Drive one pixel during accumulation. The model counts it only if the
    // pixel meets the hit rule.
    task automatic drive_accum_pixel(input bit v, input int x, input int y, input int c, input int h);
        apply_stimulus(v, x, y, c, h, 1'b0);
        tick();
        if (qualifies(v, x, y, c, h)) model_hit(x, y);
    endtask

    task automatic drive_noise(input int x0, input int x1, input int y0, input int y1);
        int kind = int'($urandom_range(0, 4));
        bit v    = 1'b1;
        int x    = int'($urandom_range(x0, x1));
        int y    = int'($urandom_range(y0, y1));
        int c    = int'($urandom_range(64, 255));
        int h    = int'($urandom_range(64, 255));
        case (kind)
            0: v = 1'b0;
            1: c = int'($urandom_range(0, 63));
            2: h = int'($urandom_range(0, 63));
            3: x = int'($urandom_range(640, 2047));
            default: y = int'($urandom_range(480, 2047));
        endcase
        drive_accum_pixel(v, x, y, c, h);
    endtask

    // Hits inside the box, with the two corners first so the box is exact,
    // interleaved with pixels that must be rejected.
    task automatic drive_hits(input int n, input int x0, input int x1, input int y0, input int y1);
        int x;
        int y;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) drive_noise(x0, x1, y0, y1);
            if (i == 0)      begin x = x0; y = y0; end
            else if (i == 1) begin x = x1; y = y1; end
            else begin
                x = int'($urandom_range(x0, x1));
                y = int'($urandom_range(y0, y1));
            end
            drive_accum_pixel(1'b1, x, y, int'($urandom_range(64, 255)),
                              ($urandom_range(0, 3) == 0) ? 64 : int'($urandom_range(64, 255)));
        end
    endtask

    // From WAIT_FRAME: open a frame, collect hits, close it, and step
    // through EVAL into PUBLISH.
    task automatic accumulate_and_close(input int n, input int x0, input int x1,
                                        input int y0, input int y1);
        repeat ($urandom_range(0, 2)) begin
            apply_stimulus(1'b1, x0, y0, 200, 200, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b1);
        tick();
        m_count = 0;
        drive_hits(n, x0, x1, y0, y1);
        apply_stimulus(1'($urandom_range(0, 1)), x0, y0, 255, 255, 1'b1);
        tick();
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b0);
        res_ready = 1'($urandom_range(0, 1));
        tick();
        model_publish();
    endtask

    // Hold the result, optionally pulse frame_start while it waits, then
    // accept it.
    task automatic finish_publish(input int hold, input bit ovr_pulse, input bit en_after);
        if (!en_after) enable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            res_ready   = 1'b0;
            frame_start = ovr_pulse && (i == hold / 2);
            tick();
            if (frame_start) exp_overrun = 1'b1;
        end
        frame_start = 1'b0;
        res_ready   = 1'b1;
        tick();
        exp_valid = 1'b0;
        exp_busy  = en_after;
        res_ready = 1'b0;
        if (!en_after) begin
            repeat (2) tick();
            enable = 1'b1;
            tick();
            exp_busy = 1'b1;
        end
    endtask

    initial begin
        int n;
        int x0;
        int x1;
        int y0;
        int y1;
        RST = 1'b1; enable = 1'b0; res_ready = 1'b0;
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b0);
        model_reset();
        tick();
        check_en = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        exp_busy = 1'b1;

        // 120 hits in x 100..140, y 200..260.
        accumulate_and_close(120, 100, 140, 200, 260);
        check_output("lit_det_120", 32'(hand_detected), 32'd1);
        check_output("lit_x_120", 32'(hand_x), 32'd120);
        check_output("lit_y_120", 32'(hand_y), 32'd230);
        check_output("lit_hits_120", 32'(hit_count), 32'd120);
        finish_publish(0, 1'b0, 1'b1);

        // 99 hits: just below the threshold, so the centre is held.
        accumulate_and_close(99, 100, 140, 200, 260);
        check_output("lit_det_99", 32'(hand_detected), 32'd0);
        check_output("lit_hits_99", 32'(hit_count), 32'd99);
        check_output("lit_x_99", 32'(hand_x), 32'd120);
        finish_publish(2, 1'b0, 1'b1);

        // Pixels that must all be rejected.
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b1);
        tick();
        m_count = 0;
        drive_accum_pixel(1'b1, 120, 230, 200, 63);
        drive_accum_pixel(1'b1, 120, 230, 63, 200);
        drive_accum_pixel(1'b1, 700, 230, 200, 200);
        drive_accum_pixel(1'b1, 120, 480, 200, 200);
        drive_accum_pixel(1'b0, 120, 230, 200, 200);
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b1);
        tick();
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b0);
        tick();
        model_publish();
        check_output("lit_hits_reject", 32'(hit_count), 32'd0);
        finish_publish(1, 1'b0, 1'b1);

        // Long hold with a frame_start while publishing.
        accumulate_and_close(130, 10, 50, 20, 60);
        finish_publish(10, 1'b1, 1'b1);
        check_output("lit_overrun", 32'(overrun), 32'd1);

        // Dropping enable mid-frame discards it.
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b1);
        tick();
        m_count = 0;
        drive_hits(150, 300, 400, 100, 200);
        enable = 1'b0;
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b0);
        tick();
        exp_busy = 1'b0;
        check_output("lit_busy_drop", 32'(busy), 32'd0);
        repeat (3) begin
            apply_stimulus(1'b0, 0, 0, 0, 0, 1'b1);
            tick();
        end
        apply_stimulus(1'b0, 0, 0, 0, 0, 1'b0);
        enable = 1'b1;
        tick();
        exp_busy = 1'b1;
        accumulate_and_close(0, 0, 10, 0, 10);
        check_output("lit_hits_empty", 32'(hit_count), 32'd0);
        finish_publish(0, 1'b0, 1'b0);

        // Two detected centres, (100,100) and then (200,300).
        accumulate_and_close(110, 80, 120, 90, 110);
        check_output("lit_x_first", 32'(hand_x), 32'd100);
        finish_publish(0, 1'b0, 1'b1);
        accumulate_and_close(110, 180, 220, 280, 320);
`ifdef HAND_SMOOTH_EN
        check_output("lit_x_second", 32'(hand_x), 32'd150);
        check_output("lit_y_second", 32'(hand_y), 32'd200);
`else
        check_output("lit_x_second", 32'(hand_x), 32'd200);
        check_output("lit_y_second", 32'(hand_y), 32'd300);
`endif
        finish_publish(1, 1'b0, 1'b1);

        // Randomized frames, with counts clustered around the threshold.
        for (int f = 0; f < 14; f++) begin
            n  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(98, 101)) : int'($urandom_range(0, 220));
            x0 = int'($urandom_range(0, 600));
            x1 = int'($urandom_range(x0, ROI_X1));
            y0 = int'($urandom_range(0, 440));
            y1 = int'($urandom_range(y0, ROI_Y1));
            accumulate_and_close(n, x0, x1, y0, y1);
            finish_publish(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset while a result is pending.
        accumulate_and_close(140, 200, 260, 100, 180);
        res_ready = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        tick();
        model_reset();
        RST = 1'b0;
        tick();
        exp_busy = 1'b1;
        check_output("lit_valid_after_rst", 32'(res_valid), 32'd0);
        accumulate_and_close(105, 30, 90, 40, 80);
        finish_publish(0, 1'b0, 1'b1);
        tick();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hand_frame_scheduler.md
Name: hand_frame_scheduler

Overview:
Per-frame controller for the hand recognition path of the pong game. It opens an accumulation window at each frame start and qualifies contour and convex-hull pixels inside a fixed region of interest (ROI). It tracks the hit count and bounding box, evaluates at the next frame start, and publishes the hand centre to the paddle logic over a valid/ready handshake.

Parameters:
PIX_THRESHOLD, 8'd64, per-pixel minimum for both contour_data and hull_data
HIT_THRESHOLD, 100, minimum qualifying pixels per frame to declare a hand
ROI_X0, 0, ROI left column, inclusive
ROI_X1, 639, ROI right column, inclusive
ROI_Y0, 0, ROI top row, inclusive
ROI_Y1, 479, ROI bottom row, inclusive

Ports:
VGA_CLK  in  1  sole clock
RST  in  1  synchronous active-high reset
enable  in  1  run request; low parks the block in IDLE
frame_start  in  1  one-cycle pulse at start of frame (vsync edge)
pixel_valid  in  1  pixel_x, pixel_y and data are valid this cycle
pixel_x  in  11  current pixel column
pixel_y  in  11  current pixel row
contour_data  in  8  contour detector output for current pixel
hull_data  in  8  convex hull output for current pixel
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
hand_detected  out  1  hand present in last published frame
hand_x  out  11  hand centre column
hand_y  out  11  hand centre row
hit_count  out  20  qualifying pixel count of last published frame
busy  out  1  high in any state except IDLE
overrun  out  1  sticky: a frame_start arrived while in PUBLISH

Behaviour:
- Reset: state IDLE. All outputs 0. Internal accumulators cleared.
- Hit rule: pixel_valid and contour_data >= PIX_THRESHOLD and hull_data >= PIX_THRESHOLD and ROI_X0<=pixel_x<=ROI_X1 and ROI_Y0<=pixel_y<=ROI_Y1.
- States:
  - IDLE: when enable=1, go to WAIT_FRAME.
  - WAIT_FRAME: on frame_start, clear accumulators and go to ACCUM. Pixels are ignored in this state.
  - ACCUM: on each hit, increment acc_count, saturating at 20'hFFFFF.
    - First hit of the frame loads xmin=xmax=pixel_x and ymin=ymax=pixel_y.
    - Later hits widen the bounding box.
    - On frame_start, go to EVAL. A pixel hit in the same cycle is not counted.
  - EVAL (1 cycle): det = acc_count >= HIT_THRESHOLD.
    - Latch hit_count=acc_count and hand_detected=det.
    - If det: hand_x=(xmin+xmax)>>1 and hand_y=(ymin+ymax)>>1, summed at 12 bits with no overflow.
    - If not det: hand_x and hand_y hold their previous values.
    - Set res_valid=1 and go to PUBLISH.
  - PUBLISH: res_valid stays high and outputs stay stable until res_valid&&res_ready.
    - On that cycle res_valid drops next cycle.
    - Next state is WAIT_FRAME if enable=1, else IDLE.
    - Acceptance is possible on the first PUBLISH cycle.
    - A frame_start seen in PUBLISH sets overrun; that frame is dropped.
- Latency: res_valid rises 2 cycles after the closing frame_start: EVAL, then registered outputs.
- enable=0 in WAIT_FRAME or ACCUM: go to IDLE next cycle and discard partial accumulation. res_valid is not raised.
- enable=0 in EVAL or PUBLISH: the publish completes first.
- overrun clears only on RST.
- RST mid-operation overrides everything, including a pending res_valid.

Optional Feature:
Macro HAND_SMOOTH_EN.
- Defined: on a detected frame, hand_x=(prev_x+new_x)>>1 and likewise for hand_y. This applies only when the previous published frame was also detected; otherwise the raw centre is loaded.
- Undefined: raw centre is output.

Test Plan:
- Reset, enable=1, frame_start, 120 hit pixels in box x 100..140, y 200..260, frame_start → res_valid after 2 cycles; hand_detected=1, hand_x=120, hand_y=230, hit_count=120.
- Same frame with 99 hits → hand_detected=0, hit_count=99, hand_x/hand_y unchanged from the previous result.
- Pixels with contour_data=200, hull_data=63, or pixel_x=700 while ROI_X1=639 → not counted; hit_count=0.
- Hold res_ready=0 for 10 cycles and pulse frame_start during PUBLISH → res_valid and outputs stable; overrun=1; on res_ready the block returns to WAIT_FRAME.
- Drop enable mid-ACCUM after 150 hits → IDLE next cycle, busy=0, no res_valid. Re-enable with an empty frame → hit_count=0.
- HAND_SMOOTH_EN: detected centres (100,100) then (200,300) → second result is hand_x=150, hand_y=200.
